pixel_stream_framer: RTL and testbench

//  Sits directly downstream of the pixel inverter stage. Absorbs its registered valid,

---
 rtl/pixel_stream_framer_if.sv | 16 +
 rtl/pixel_stream_framer.sv | 147 ++++++++++++++
 tb/tb_pixel_stream_framer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_framer_if.sv
// Pixel stream interface: valid/ready handshake plus a data word and the
// video sideband flags (last = end of line, user = start of frame).
// The slave view carries only the handshake and data, because the framer
// generates the sideband flags itself rather than accepting them from upstream.
interface pixel_stream_framer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic                  last;
   logic                  user;

   modport master (output valid, output data, output last, output user, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pixel_stream_framer.sv
// pixel_stream_framer: absorbs a late-valid upstream pixel stream in a small
// first-word-fall-through FIFO and re-emits it as a video stream with
// end-of-line (last) and start-of-frame (user) flags.
// Optional feature: define FRAMER_FRAME_CNT_EN to add a 16-bit frame_count output.
module pixel_stream_framer #(
   parameter int DATA_WIDTH      = 32,
   parameter int FIFO_DEPTH      = 8,
   parameter int WORDS_PER_LINE  = 160,
   parameter int LINES_PER_FRAME = 480
) (
   input  logic                   axi_clk,
   input  logic                   axi_reset,
   input  logic                   soft_clr,
   pixel_stream_framer_if.slave   s_axis,
   pixel_stream_framer_if.master  m_axis,
   output logic                   overflow,
   output logic                   frame_done
`ifdef FRAMER_FRAME_CNT_EN
   ,
   output logic [15:0]            frame_count
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(WORDS_PER_LINE);
   localparam int RW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
   localparam logic [AW:0]   FULL_C      = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   READY_MAX_C = (AW+1)'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0] COL_LAST_C  = CW'(WORDS_PER_LINE - 1);
   localparam logic [RW-1:0] ROW_LAST_C  = RW'(LINES_PER_FRAME - 1);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          ready_q, ready_d;
   logic          overflow_q, overflow_d;
   logic          frame_done_q, frame_done_d;
   logic          rd, wr, wr_en, line_last, frame_first;

   // Output side: FWFT head word and sideband flags from registered state,
   // so everything holds steady while the consumer stalls.
   assign line_last     = (col_q == COL_LAST_C);
   assign frame_first   = (col_q == '0) && (row_q == '0);
   assign m_axis.valid  = (count_q != '0);
   assign m_axis.data   = mem[rd_ptr_q];
   assign m_axis.last   = line_last;
   assign m_axis.user   = frame_first;
   assign s_axis.ready  = ready_q;
   assign overflow      = overflow_q;
   assign frame_done    = frame_done_q;

   // Next-state logic: FIFO occupancy, drop detection and line/frame counters.
   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      col_d        = col_q;
      row_d        = row_q;
      overflow_d   = overflow_q;
      frame_done_d = 1'b0;

      rd = m_axis.valid & m_axis.ready;
      // Upstream valid lags its ready by a cycle, so ready is not used to
      // qualify writes; a word arriving while full is only kept if a read
      // frees its slot in the same cycle.
      wr = s_axis.valid & ((count_q < FULL_C) | rd);
      wr_en = wr & ~soft_clr;

      if (soft_clr) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         col_d      = '0;
         row_d      = '0;
         overflow_d = 1'b0;
      end else begin
         if (wr) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rd) rd_ptr_d = rd_ptr_q + 1'b1;
         case ({wr, rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
         if (s_axis.valid && (count_q == FULL_C) && !rd) overflow_d = 1'b1;
         if (rd) begin
            frame_done_d = line_last && (row_q == ROW_LAST_C);
            if (line_last) begin
               col_d = '0;
               row_d = (row_q == ROW_LAST_C) ? '0 : row_q + 1'b1;
            end else begin
               col_d = col_q + 1'b1;
            end
         end
      end
      // Two free slots whenever ready is high cover the upstream skid word.
      ready_d = (count_d <= READY_MAX_C);
   end

   // State registers.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         col_q        <= '0;
         row_q        <= '0;
         ready_q      <= 1'b1;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         col_q        <= col_d;
         row_q        <= row_d;
         ready_q      <= ready_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
      end
   end

   // FIFO storage write port; contents need no reset since count gates reads.
   always_ff @(posedge axi_clk) begin
      if (wr_en) mem[wr_ptr_q] <= s_axis.data;
   end

`ifdef FRAMER_FRAME_CNT_EN
   logic [15:0] frame_count_q, frame_count_d;

   // Completed-frame counter, stepping alongside the frame_done pulse.
   always_comb begin
      frame_count_d = frame_count_q + {15'd0, frame_done_d};
      if (soft_clr) frame_count_d = '0;
   end

   // Frame counter register.
   always_ff @(posedge axi_clk or posedge axi_reset) begin
      if (axi_reset) frame_count_q <= '0;
      else           frame_count_q <= frame_count_d;
   end

   assign frame_count = frame_count_q;
`endif
endmodule

// File: tb/tb_pixel_stream_framer.sv
// Directed bench for pixel_stream_framer with a scoreboard queue: words are
// pushed when driven (if they should be kept) and popped when they leave.
module tb_pixel_stream_framer;
   localparam int DW  = 32;
   localparam int WPL = 4;
   localparam int LPF = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic soft_clr = 1'b0;
   logic overflow, frame_done;
`ifdef FRAMER_FRAME_CNT_EN
   logic [15:0] frame_count;
`endif

   pixel_stream_framer_if #(.DATA_WIDTH(DW)) s_if ();
   pixel_stream_framer_if #(.DATA_WIDTH(DW)) m_if ();

   assign s_if.last = 1'b0;
   assign s_if.user = 1'b0;

   pixel_stream_framer #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(4), .WORDS_PER_LINE(WPL), .LINES_PER_FRAME(LPF)
   ) dut (
      .axi_clk    (clk),
      .axi_reset  (rst),
      .soft_clr   (soft_clr),
      .s_axis     (s_if),
      .m_axis     (m_if),
      .overflow   (overflow),
      .frame_done (frame_done)
`ifdef FRAMER_FRAME_CNT_EN
      ,
      .frame_count(frame_count)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int fd_cnt = 0;
   logic [DW-1:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Output monitor and reference model of the line/frame position.
   int  mcol = 0;
   int  mrow = 0;
   bit  fd_pending = 1'b0;
   logic [DW-1:0] exp_word;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         mcol = 0; mrow = 0; fd_pending = 1'b0;
      end else begin
         check("frame_done", {31'd0, frame_done}, {31'd0, fd_pending});
         if (frame_done) fd_cnt++;
         fd_pending = 1'b0;
         if (soft_clr) begin
            exp_q.delete();
            mcol = 0; mrow = 0;
         end else if (m_if.valid && m_if.ready) begin
            $display("xfer data=%08h last=%0b user=%0b", m_if.data, m_if.last, m_if.user);
            check("word_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               exp_word = exp_q.pop_front();
               check("data", m_if.data, exp_word);
               check("last", {31'd0, m_if.last}, {31'd0, mcol == WPL-1});
               check("user", {31'd0, m_if.user}, {31'd0, (mcol == 0) && (mrow == 0)});
            end
            if (mcol == WPL-1) begin
               mcol = 0;
               if (mrow == LPF-1) begin
                  mrow = 0;
                  fd_pending = 1'b1;
               end else begin
                  mrow++;
               end
            end else begin
               mcol++;
            end
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input bit keep);
      s_if.valid = 1'b1;
      s_if.data  = d;
      if (keep) exp_q.push_back(d);
      @(posedge clk); #1;
      s_if.valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      m_if.ready = 1'b1;
      while (exp_q.size() != 0 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_soft_clr();
      soft_clr = 1'b1;
      @(posedge clk); #1;
      soft_clr = 1'b0;
   endtask

   initial begin
      s_if.valid = 1'b0;
      s_if.data  = '0;
      m_if.ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_m_valid", {31'd0, m_if.valid}, 32'd0);
      check("rst_overflow", {31'd0, overflow}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_s_ready", {31'd0, s_if.ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: one full frame with the consumer always ready
      m_if.ready = 1'b1;
      send(32'h01, 1'b1);
      check("latency_valid", {31'd0, m_if.valid}, 32'd1);
      check("latency_data", m_if.data, 32'h01);
      for (int i = 2; i <= 8; i++) send(DW'(i), 1'b1);
      drain();
      check("frame_done_count", fd_cnt, 32'd1);

      // 2: consumer stalled, overfill the FIFO
      m_if.ready = 1'b0;
      send(32'hA0, 1'b1);
      send(32'hA1, 1'b1);
      check("s_ready_at_2", {31'd0, s_if.ready}, 32'd1);
      send(32'hA2, 1'b1);
      check("s_ready_at_3", {31'd0, s_if.ready}, 32'd0);
      send(32'hA3, 1'b1);
      check("overflow_before_drop", {31'd0, overflow}, 32'd0);
      send(32'hA4, 1'b0);
      check("overflow_set", {31'd0, overflow}, 32'd1);
      send(32'hA5, 1'b0);
      check("stall_head", m_if.data, 32'hA0);
      drain();
      check("overflow_sticky", {31'd0, overflow}, 32'd1);
      pulse_soft_clr();
      check("overflow_cleared", {31'd0, overflow}, 32'd0);

      // 3: write and read together while full
      m_if.ready = 1'b0;
      for (int i = 0; i < 4; i++) send(DW'(32'hC0 + i), 1'b1);
      m_if.ready = 1'b1;
      send(32'hB0, 1'b1);
      m_if.ready = 1'b0;
      check("full_rw_overflow", {31'd0, overflow}, 32'd0);
      check("full_rw_s_ready", {31'd0, s_if.ready}, 32'd0);
      check("full_rw_head", m_if.data, 32'hC1);
      @(posedge clk); #1;
      check("full_rw_overflow_hold", {31'd0, overflow}, 32'd0);
      drain();

      // 4: stall on an end-of-line word
      m_if.ready = 1'b0;
      send(32'hE0, 1'b1);
      send(32'hE1, 1'b1);
      send(32'hE2, 1'b1);
      m_if.ready = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      m_if.ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_valid", {31'd0, m_if.valid}, 32'd1);
         check("stall_data", m_if.data, 32'hE2);
         check("stall_last", {31'd0, m_if.last}, 32'd1);
         check("stall_user", {31'd0, m_if.user}, 32'd0);
         @(posedge clk); #1;
      end
      drain();

      // 5a: async reset mid-line
      m_if.ready = 1'b1;
      send(32'hF0, 1'b1);
      send(32'hF1, 1'b1);
      send(32'hF2, 1'b1);
      rst = 1'b1;
      #1;
      check("arst_m_valid", {31'd0, m_if.valid}, 32'd0);
      check("arst_overflow", {31'd0, overflow}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      send(32'h60, 1'b1);
      check("arst_next_user", {31'd0, m_if.user}, 32'd1);
      drain();

      // 5b: soft clear mid-frame with an overflowed FIFO
      for (int i = 0; i < 5; i++) send(DW'(32'h70 + i), 1'b1);
      drain();
      m_if.ready = 1'b0;
      for (int i = 0; i < 6; i++) send(DW'(32'h80 + i), i < 4);
      check("pre_clr_overflow", {31'd0, overflow}, 32'd1);
      pulse_soft_clr();
      check("clr_m_valid", {31'd0, m_if.valid}, 32'd0);
      check("clr_overflow", {31'd0, overflow}, 32'd0);
      check("clr_s_ready", {31'd0, s_if.ready}, 32'd1);
      m_if.ready = 1'b1;
      send(32'h90, 1'b1);
      check("clr_next_user", {31'd0, m_if.user}, 32'd1);
      check("clr_next_last", {31'd0, m_if.last}, 32'd0);
      drain();

`ifdef FRAMER_FRAME_CNT_EN
      // 6: three full frames counted
      pulse_soft_clr();
      check("fc_cleared", {16'd0, frame_count}, 32'd0);
      m_if.ready = 1'b1;
      for (int i = 0; i < 3*WPL*LPF; i++) send(DW'(32'h100 + i), 1'b1);
      drain();
      check("frame_count", {16'd0, frame_count}, 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
